// File: rtl/itcm_port_arbiter.sv
// Arbitrates the single-port ITCM SRAM between fetch, data and auto-load requesters
// and steers the one-cycle-late read data back to whichever requester issued the read.
module itcm_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ITCM_AW      = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  instr_itcm_access,
  input  logic [ADDR_WIDTH-1:0] instr_itcm_addr,
  output logic                  instr_itcm_grant,
  output logic [DATA_WIDTH-1:0] instr_itcm_read_data,
  output logic                  instr_itcm_read_data_valid,
  input  logic                  data_itcm_access,
  input  logic                  data_itcm_write,
  input  logic [ADDR_WIDTH-1:0] data_itcm_addr,
  input  logic [DATA_WIDTH-1:0] data_itcm_wdata,
  input  logic [3:0]            data_itcm_wstrb,
  output logic                  data_itcm_grant,
  output logic [DATA_WIDTH-1:0] data_itcm_read_data,
  output logic                  data_itcm_read_data_valid,
  input  logic                  itcm_auto_load,
  input  logic                  al_valid,
  output logic                  al_ready,
  input  logic [ADDR_WIDTH-1:0] al_addr,
  input  logic [DATA_WIDTH-1:0] al_wdata,
  output logic                  itcm_cs,
  output logic                  itcm_we,
  output logic [ITCM_AW-1:0]    itcm_addr,
  output logic [DATA_WIDTH-1:0] itcm_wdata,
  output logic [3:0]            itcm_wstrb,
  input  logic [DATA_WIDTH-1:0] itcm_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {RUN, LOAD, DRAIN} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_e;

  state_e                  state_q, state_d;
  owner_e                  rd_owner_q, rd_owner_d;
  logic [3:0]              starve_cnt_q, starve_cnt_d;
  logic [ITCM_AW-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    fetch_win;

  // Only the word-address slice of each byte address reaches the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_itcm_addr, data_itcm_addr, al_addr};

  always_comb begin
    state_d          = state_q;
    rd_owner_d       = OWN_NONE;
    starve_cnt_d     = starve_cnt_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    fetch_win        = 1'b0;
    instr_itcm_grant = 1'b0;
    data_itcm_grant  = 1'b0;
    al_ready         = 1'b0;
    itcm_cs          = 1'b0;
    itcm_we          = 1'b0;
    itcm_wstrb       = '0;

    unique case (state_q)
      RUN: begin
        if (itcm_auto_load) state_d = LOAD;
        fetch_win        = instr_itcm_access & ((starve_cnt_q == LIMIT) | ~data_itcm_access);
        instr_itcm_grant = fetch_win;
        data_itcm_grant  = data_itcm_access & ~fetch_win;
        if (instr_itcm_grant) begin
          itcm_cs    = 1'b1;
          itcm_wstrb = 4'hF;
          addr_d     = instr_itcm_addr[ITCM_AW+1:2];
          rd_owner_d = OWN_FETCH;
        end else if (data_itcm_grant) begin
          itcm_cs    = 1'b1;
          itcm_we    = data_itcm_write;
          itcm_wstrb = data_itcm_wstrb;
          addr_d     = data_itcm_addr[ITCM_AW+1:2];
          wdata_d    = data_itcm_wdata;
          rd_owner_d = data_itcm_write ? OWN_NONE : OWN_DATA;
        end
      end
      LOAD: begin
        if (!itcm_auto_load) state_d = DRAIN;
        al_ready = 1'b1;
        if (al_valid) begin
          itcm_cs    = 1'b1;
          itcm_we    = 1'b1;
          itcm_wstrb = 4'hF;
          addr_d     = al_addr[ITCM_AW+1:2];
          wdata_d    = al_wdata;
        end
      end
      default: state_d = RUN;
    endcase

    // Counter holds while fetch waits outside RUN; only data wins advance it.
    if (!instr_itcm_access || instr_itcm_grant) starve_cnt_d = '0;
    else if (data_itcm_grant && starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  assign itcm_addr  = addr_d;
  assign itcm_wdata = wdata_d;

  assign instr_itcm_read_data_valid = (rd_owner_q == OWN_FETCH);
  assign data_itcm_read_data_valid  = (rd_owner_q == OWN_DATA);
  assign instr_itcm_read_data       = instr_itcm_read_data_valid ? itcm_rdata : '0;
  assign data_itcm_read_data        = data_itcm_read_data_valid  ? itcm_rdata : '0;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q      <= RUN;
      rd_owner_q   <= OWN_NONE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule
